uart_rx_deser: RTL and testbench
================================

// Module: uart_rx_deser
// PURPOSE
// - 8N1 UART receiver: deserialises the BLE module's TX line into bytes and
//   offers them through a rdy/clr_rdy handshake.
// - Sits directly upstream of the authentication FSM, which reads rx_data on
//   rdy and pulses clr_rdy. Also reports framing and overrun errors.
// PARAMETERS
// - BAUD_DIV  2604  clocks per bit (50 MHz / 19200 baud); legal range >= 8
// - HALF_DIV  BAUD_DIV/2  clocks from start-bit detect to start-bit mid-sample
// PORTS
// - clk      in   1  system clock; all logic on rising edge
// - rst_n    in   1  reset, synchronous, active-low
// - RX       in   1  async serial input; idles high
// - clr_rdy  in   1  consumer ack; clears rdy and ovr
// - rdy      out  1  rx_data holds a valid unread byte
// - rx_data  out  8  last correctly framed byte
// - frm_err  out  1  last frame had stop bit = 0; held until next frame completes
// - ovr      out  1  sticky; a byte completed while rdy was already 1
// BEHAVIOUR
// - Reset values: rdy=0, rx_data=8'h00, frm_err=0, ovr=0, state=IDLE,
//   both sync flops=1, prev-sample flop=1. Reset mid-frame aborts the frame.
//   No rdy pulse and no output change after the reset edge.
// - RX passes through a 2-flop synchroniser. Only the synced signal is used.
//   A prev-sample flop of it is used for edge detection.
// - Baud counter width is $clog2(BAUD_DIV+1). It loads, counts down, and
//   samples at 0. Bit counter is 4 bits.
// - FSM states:
//   - IDLE:  on synced falling edge (prev=1, cur=0), load HALF_DIV -> START.
//            A held-low line (break) does not retrigger.
//   - START: at expiry, if synced RX=0 -> DATA (load BAUD_DIV, bit_cnt=0).
//            If synced RX=1 -> glitch, back to IDLE with no output change.
//   - DATA:  at each expiry, shift right with synced RX into bit 7 (LSB
//            first) and bit_cnt++. Reload BAUD_DIV. After 8th bit -> STOP.
//   - STOP:  at expiry, if RX=1: rx_data<=shift, rdy<=1, frm_err<=0.
//            If RX=0: frm_err<=1, rdy and rx_data unchanged. Both -> IDLE.
// - Latency: rdy rises 2 + HALF_DIV + 9*BAUD_DIV (+/-1) clocks after the
//   RX pin falls.
// - Handshake: rdy stays 1 until clr_rdy is sampled high. clr_rdy while
//   rdy=0 has no effect.
// - Overrun: a good frame completes while rdy=1 -> rx_data overwritten,
//   rdy stays 1, ovr<=1. clr_rdy clears rdy and ovr.
// - Same-cycle good completion and clr_rdy: completion wins. rdy=1 with the
//   new byte, ovr not set, and ovr cleared if it was set.
// - Framing error does not touch rdy/ovr. clr_rdy does not clear frm_err.
// - Counters hold when not in use. No state is reachable other than the
//   four above; default case returns to IDLE.
// TESTING (BAUD_DIV=16, HALF_DIV=8)
// - Send 0x67 8N1 -> rdy rises 154+/-1 clocks after start edge,
//   rx_data=0x67, frm_err=0. Pulse clr_rdy -> rdy=0 next clock.
// - RX low for 3 clocks then high -> no rdy, FSM back in IDLE.
//   Then send 0x73 -> rx_data=0x73.
// - Send 0xA5 with stop bit 0 -> frm_err=1, rdy=0, rx_data unchanged.
//   Then a good 0x3C -> frm_err=0, rdy=1.
// - Send 0x67 then 0x73 without clr_rdy -> rdy=1, rx_data=0x73, ovr=1.
//   clr_rdy -> rdy=0, ovr=0.
// - Assert clr_rdy in the exact cycle a frame completes -> rdy=1,
//   ovr=0, rx_data = new byte.
// - Drop rst_n mid-data-bit 4 for 1 clock -> all outputs at reset values,
//   no rdy. Next full frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_rx_deser_if.sv
// rtl/uart_rx_deser_if.sv - serial line and byte handshake bundle for uart_rx_deser
//
// Purpose: groups the receiver's serial input and consumer-side handshake.
// Signals:
//   RX       serial line from the BLE module, idles high
//   clr_rdy  consumer acknowledge; clears rdy and ovr
//   rdy      rx_data holds an unread byte
//   rx_data  last correctly framed byte
//   frm_err  last frame ended with a low stop bit
//   ovr      sticky overrun flag
// Modports:
//   master  receiver side (drives the byte outputs)
//   slave   line driver / consumer side
interface uart_rx_deser_if;
  logic       RX;
  logic       clr_rdy;
  logic       rdy;
  logic [7:0] rx_data;
  logic       frm_err;
  logic       ovr;

  modport master (
    input  RX,
    input  clr_rdy,
    output rdy,
    output rx_data,
    output frm_err,
    output ovr
  );

  modport slave (
    output RX,
    output clr_rdy,
    input  rdy,
    input  rx_data,
    input  frm_err,
    input  ovr
  );
endinterface

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - 8N1 UART receiver with rdy/clr_rdy byte handshake
//
// Purpose: deserialises an asynchronous 8N1 line into bytes, flags framing
// errors and overruns, and holds each byte until the consumer acknowledges.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    uart_rx_deser_if.master: RX, clr_rdy in; rdy, rx_data, frm_err, ovr out
// Parameters:
//   BAUD_DIV  clocks per bit (>= 8)
//   HALF_DIV  clocks from start-edge detect to the start-bit mid-sample
module uart_rx_deser #(
  parameter int BAUD_DIV = 2604,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_rx_deser_if.master    bus
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  // The counter samples on the cycle it reads zero, so loading N-1 gives a
  // spacing of exactly N clocks between samples.
  localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_rdy;
  logic [7:0]    r_data;
  logic          r_frm;
  logic          r_ovr;

  state_t        w_state_nxt;
  logic          w_rx;
  logic          w_fall;
  logic          w_expire;
  logic          w_cnt_ld;
  logic [CW-1:0] w_cnt_val;
  logic          w_cnt_dec;
  logic          w_shift_en;
  logic          w_bit_clr;
  logic          w_good;
  logic          w_bad;

  assign w_rx     = r_sync2;
  // Edge-only trigger: a line held low (break) never restarts a frame.
  assign w_fall   = r_prev & ~r_sync2;
  assign w_expire = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_ld    = 1'b0;
    w_cnt_val   = BAUD_LD;
    w_cnt_dec   = 1'b0;
    w_shift_en  = 1'b0;
    w_bit_clr   = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_cnt_ld    = 1'b1;
          w_cnt_val   = HALF_LD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (!w_rx) begin
            w_cnt_ld    = 1'b1;
            w_bit_clr   = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_en = 1'b1;
          w_cnt_ld   = 1'b1;
          if (r_bit_cnt == 4'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          w_good      = w_rx;
          w_bad       = ~w_rx;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev    <= 1'b1;
      r_cnt     <= '0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_rdy     <= 1'b0;
      r_data    <= 8'h00;
      r_frm     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync1 <= bus.RX;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_state_nxt;

      if (w_cnt_ld) begin
        r_cnt <= w_cnt_val;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_bit_clr) begin
        r_bit_cnt <= 4'd0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      // LSB arrives first, so each new bit enters at the top.
      if (w_shift_en) begin
        r_shift <= {w_rx, r_shift[7:1]};
      end

      if (w_good) begin
        // A completing byte wins over a same-cycle acknowledge; the ack
        // still counts as having consumed the old byte, so ovr clears.
        r_data <= r_shift;
        r_rdy  <= 1'b1;
        r_frm  <= 1'b0;
        if (bus.clr_rdy) begin
          r_ovr <= 1'b0;
        end else if (r_rdy) begin
          r_ovr <= 1'b1;
        end
      end else begin
        if (w_bad) begin
          r_frm <= 1'b1;
        end
        if (bus.clr_rdy) begin
          r_rdy <= 1'b0;
          r_ovr <= 1'b0;
        end
      end
    end
  end

  assign bus.rdy     = r_rdy;
  assign bus.rx_data = r_data;
  assign bus.frm_err = r_frm;
  assign bus.ovr     = r_ovr;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - directed table-driven bench for uart_rx_deser
module tb_uart_rx_deser;

  localparam int BAUD = 16;
  localparam int HALF = 8;

  logic clk;
  logic rst_n;

  uart_rx_deser_if bus ();

  uart_rx_deser #(
    .BAUD_DIV (BAUD),
    .HALF_DIV (HALF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr_first;
    logic       exp_rdy;
    logic [7:0] exp_data;
    logic       exp_frm;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [9];
  int   n_checks;
  int   n_errors;
  int   lat;
  bit   seen;
  logic [7:0] d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop);
    @(posedge clk);
    #1 bus.RX = 1'b0;
    repeat (BAUD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 bus.RX = v[i];
      repeat (BAUD) @(posedge clk);
    end
    #1 bus.RX = stop;
    repeat (BAUD) @(posedge clk);
    #1 bus.RX = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 bus.clr_rdy = 1'b1;
    @(posedge clk);
    #1 bus.clr_rdy = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic e_rdy, input logic [7:0] e_data,
                            input logic e_frm, input logic e_ovr);
    @(negedge clk);
    check({tag, ".rdy"}, 32'(bus.rdy), 32'(e_rdy));
    check({tag, ".rx_data"}, 32'(bus.rx_data), 32'(e_data));
    check({tag, ".frm_err"}, 32'(bus.frm_err), 32'(e_frm));
    check({tag, ".ovr"}, 32'(bus.ovr), 32'(e_ovr));
  endtask

  task automatic apply_vec(input int k);
    if (vecs[k].clr_first) pulse_clr();
    send_frame(vecs[k].data, vecs[k].stop);
    repeat (4) @(posedge clk);
    check_outs($sformatf("vec%0d", k), vecs[k].exp_rdy, vecs[k].exp_data,
               vecs[k].exp_frm, vecs[k].exp_ovr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //           data   stop  clr   rdy   data   frm   ovr
    vecs[0] = '{8'h73, 1'b1, 1'b0, 1'b1, 8'h73, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'h73, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'h67, 1'b1, 1'b1, 1'b1, 8'h67, 1'b0, 1'b0};
    vecs[6] = '{8'h73, 1'b1, 1'b0, 1'b1, 8'h73, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};

    rst_n       = 1'b0;
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    check_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0);

    // First byte with latency measured from the pin's falling edge.
    lat  = 0;
    seen = 1'b0;
    fork
      send_frame(8'h67, 1'b1);
      begin
        @(posedge clk);
        while (!seen && lat < 400) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (bus.rdy) seen = 1'b1;
        end
      end
    join
    n_checks++;
    if (!seen || lat < 153 || lat > 155) begin
      n_errors++;
      $display("FAIL latency: got %0d clocks (seen=%0d), expected 153..155", lat, seen);
      lat = 154;
    end
    repeat (4) @(posedge clk);
    check_outs("first", 1'b1, 8'h67, 1'b0, 1'b0);

    pulse_clr();
    @(negedge clk);
    check("clr.rdy", 32'(bus.rdy), 32'd0);

    // Short low glitch must not start a frame.
    @(posedge clk);
    #1 bus.RX = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.RX = 1'b1;
    repeat (40) @(posedge clk);
    check_outs("glitch", 1'b0, 8'h67, 1'b0, 1'b0);

    for (int k = 0; k < 7; k++) apply_vec(k);

    pulse_clr();
    @(negedge clk);
    check("ovr_clr.rdy", 32'(bus.rdy), 32'd0);
    check("ovr_clr.ovr", 32'(bus.ovr), 32'd0);

    for (int k = 7; k < 9; k++) apply_vec(k);

    // Acknowledge lands on the exact completion cycle while ovr is set.
    fork
      send_frame(8'h5A, 1'b1);
      begin
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 bus.clr_rdy = 1'b1;
        @(posedge clk);
        #1 bus.clr_rdy = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    check_outs("same_cycle", 1'b1, 8'h5A, 1'b0, 1'b0);

    // Reset pulse in the middle of data bit 4.
    d = 8'h0A;
    @(posedge clk);
    #1 bus.RX = 1'b0;
    repeat (BAUD) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 bus.RX = d[i];
      repeat (BAUD) @(posedge clk);
    end
    #1 bus.RX = d[4];
    repeat (BAUD / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    bus.RX = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_outs("midreset", 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (200) @(posedge clk);
    check_outs("midreset_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    send_frame(8'h55, 1'b1);
    repeat (4) @(posedge clk);
    check_outs("after_reset", 1'b1, 8'h55, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
